wr_line_assembler: RTL
======================

Name: wr_line_assembler

Overview:
- Downstream consumer of the WR UART monitor FIFO output: takes the packed 32-bit words the monitor writes (up to 4 console bytes, oldest byte in [31:24], 0x00 padding in the upper bytes when a word is flushed early on CR/LF).
- Unpacks the bytes and rebuilds complete text lines into a two-page (ping-pong) line buffer.
- Presents each finished line (length, flags, byte read port) to the IPbus slave for software readout.

Parameters:
- LINE_DEPTH, 128, bytes per page; power of 2, at least 4.
- TS_WIDTH, 32, width of the optional completion timestamp.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- word_data  in  32  packed console bytes; byte order [31:24], [23:16], [15:8], [7:0].
- word_valid  in  1  word_data valid.
- word_ready  out  1  word accepted when word_valid & word_ready.
- line_valid  out  1  a completed line is available on the read side.
- line_length  out  $clog2(LINE_DEPTH)+1  stored byte count of the presented line.
- line_overflow  out  1  presented line was truncated.
- line_rd_addr  in  $clog2(LINE_DEPTH)  byte address within the presented line.
- line_rd_data  out  8  byte at line_rd_addr, registered.
- line_done  in  1  one-cycle pulse: release the presented page.
- line_timestamp  out  TS_WIDTH  cycle count at line completion (optional feature).
- drop_count  out  16  lines lost because no free page existed; saturating.

Behaviour:
- Reset values:
  - word_ready=0, line_valid=0, line_length=0, line_overflow=0, line_rd_data=0, line_timestamp=0, drop_count=0.
  - Both pages empty; wr_page=rd_page=0; byte count=0; FSM in IDLE.
- Reset mid-line discards the partial line and any stored lines.
- FSM IDLE:
  - word_ready=1.
  - On accept: register the word, byte index=0, go to UNPACK.
- FSM UNPACK:
  - word_ready=0; process one byte per cycle, byte index 0..3 (MSB first).
  - After index 3, return to IDLE.
  - Throughput is 1 word per 5 cycles.
- Byte rules, in priority order:
  - 0x00: padding, dropped.
  - 0x0D: dropped.
  - 0x0A: terminates the line.
  - Any other byte: written to page wr_page at the current count, count+1.
  - When count == LINE_DEPTH, further bytes are dropped and the sticky overflow flag for the current line is set.
- Line termination on 0x0A:
  - count==0 and overflow==0: empty line, discarded; no commit.
  - Otherwise, if page wr_page is free: commit it.
    - Mark the page full; latch length, overflow flag and (if enabled) timestamp for that page.
    - Toggle wr_page; clear count and overflow.
  - Otherwise (page occupied): discard the line, clear count and overflow, drop_count+1 (saturates at 0xFFFF).
- Page availability while filling: if page wr_page becomes full while a line is being built, further bytes of that line are dropped. Lines are never written into an occupied page.
- Read side:
  - line_valid = full[rd_page].
  - line_length, line_overflow and line_timestamp show the values latched for rd_page.
  - line_rd_data = page[rd_page][line_rd_addr], registered, 1-cycle latency.
- line_done:
  - With line_valid=1: clear full[rd_page] and toggle rd_page. line_valid reflects the other page on the next cycle.
  - With line_valid=0: ignored.
- Latency: line_valid rises 1 cycle after the cycle in which 0x0A is processed.
- Simultaneous commit and line_done: they always target different pages; both take effect in the same cycle.

Optional Feature:
- WR_LINE_TIMESTAMP_EN defined:
  - A free-running TS_WIDTH counter, cleared by reset, wraps.
  - Its value in the termination cycle is latched per page and presented on line_timestamp.
- Not defined: no counter; line_timestamp is constant 0.

Test Plan:
- Words 0x48656C6C ("Hell"), 0x6F0D0A00 → processed bytes: 'o', 0x0D dropped, 0x0A terminates, 0x00 dropped. Expect line_valid=1, line_length=5; reads at addr 0..4 return 48 65 6C 6C 6F with 1-cycle latency.
- Monitor-style early flush 0x00000D0A alone → empty line discarded; line_valid stays 0.
- 130 non-terminator bytes then 0x0A (LINE_DEPTH=128) → line_length=128, line_overflow=1; bytes 0..127 intact.
- Three lines "A\n", "B\n", "C\n", no line_done → first two stored; third dropped, drop_count=1. Pulse line_done → line_valid=1, data 'B'.
- line_done in the same cycle a new line commits into the other page → both honoured; next line readable; no loss.
- Assert reset mid-UNPACK → all outputs return to reset values; the next full line assembles correctly from count 0. With WR_LINE_TIMESTAMP_EN, the timestamp difference between two lines equals the elapsed cycles between their terminator cycles.

Source files
------------

// File: rtl/wr_line_assembler.sv
// rtl/wr_line_assembler.sv - unpacks monitor FIFO words into ping-pong line pages (optional WR_LINE_TIMESTAMP_EN)
module wr_line_assembler #(
    parameter int LINE_DEPTH = 128,
    parameter int TS_WIDTH   = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [31:0]                   word_data,
    input  logic                          word_valid,
    output logic                          word_ready,
    output logic                          line_valid,
    output logic [$clog2(LINE_DEPTH):0]   line_length,
    output logic                          line_overflow,
    input  logic [$clog2(LINE_DEPTH)-1:0] line_rd_addr,
    output logic [7:0]                    line_rd_data,
    input  logic                          line_done,
    output logic [TS_WIDTH-1:0]           line_timestamp,
    output logic [15:0]                   drop_count
);
    localparam int AW = $clog2(LINE_DEPTH);
    localparam logic [AW:0] COUNT_MAX = LINE_DEPTH[AW:0];

    typedef enum logic {IDLE, UNPACK} state_t;

    state_t            state, state_n;
    logic              ready_q;
    logic              load;
    logic [31:0]       word_q;
    logic [1:0]        byte_idx;
    logic [7:0]        cur_byte;
    logic [AW:0]       count;
    logic              ovf;
    logic              blocked;
    logic              wr_page, rd_page;
    logic [1:0]        full, full_n;
    logic [1:0][AW:0]  len_q;
    logic [1:0]        ovf_q;
    logic [7:0]        mem [0:2*LINE_DEPTH-1];

    logic is_data, is_lf, page_busy, line_empty, wr_en, commit, drop, release_pg;

    assign word_ready    = ready_q;
    assign line_valid    = full[rd_page];
    assign line_length   = len_q[rd_page];
    assign line_overflow = ovf_q[rd_page];

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (word_valid && ready_q) begin
                    state_n = UNPACK;
                    load    = 1'b1;
                end
            end
            UNPACK: begin
                if (byte_idx == 2'd3)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        cur_byte = word_q[31:24];
        case (byte_idx)
            2'd0: cur_byte = word_q[31:24];
            2'd1: cur_byte = word_q[23:16];
            2'd2: cur_byte = word_q[15:8];
            2'd3: cur_byte = word_q[7:0];
            default: cur_byte = word_q[31:24];
        endcase
    end

    // A line that ever hit an occupied page is poisoned until its terminator, so no partial line is stored
    always_comb begin
        is_lf      = (state == UNPACK) && (cur_byte == 8'h0A);
        is_data    = (state == UNPACK) && (cur_byte != 8'h00) && (cur_byte != 8'h0D) && (cur_byte != 8'h0A);
        page_busy  = full[wr_page];
        line_empty = (count == '0) && !ovf && !blocked;
        wr_en      = is_data && !page_busy && !blocked && (count != COUNT_MAX);
        commit     = is_lf && !line_empty && !blocked && !page_busy;
        drop       = is_lf && !line_empty && (blocked || page_busy);
        release_pg = line_done && full[rd_page];
        full_n     = full;
        if (commit)
            full_n[wr_page] = 1'b1;
        if (release_pg)
            full_n[rd_page] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            word_q     <= '0;
            byte_idx   <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            blocked    <= 1'b0;
            wr_page    <= 1'b0;
            rd_page    <= 1'b0;
            full       <= '0;
            len_q      <= '0;
            ovf_q      <= '0;
            drop_count <= '0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n == IDLE);
            full    <= full_n;
            if (load) begin
                word_q   <= word_data;
                byte_idx <= 2'd0;
            end else if (state == UNPACK) begin
                byte_idx <= byte_idx + 2'd1;
            end
            if (release_pg)
                rd_page <= ~rd_page;
            if (wr_en)
                count <= count + 1'b1;
            if (is_data && (count == COUNT_MAX))
                ovf <= 1'b1;
            if (is_data && page_busy)
                blocked <= 1'b1;
            if (commit) begin
                len_q[wr_page] <= count;
                ovf_q[wr_page] <= ovf;
                wr_page        <= ~wr_page;
            end
            if (is_lf) begin
                count   <= '0;
                ovf     <= 1'b0;
                blocked <= 1'b0;
            end
            if (drop && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[{wr_page, count[AW-1:0]}] <= cur_byte;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            line_rd_data <= '0;
        else
            line_rd_data <= mem[{rd_page, line_rd_addr}];
    end

`ifdef WR_LINE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]      ts_cnt;
    logic [1:0][TS_WIDTH-1:0] ts_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (commit)
                ts_q[wr_page] <= ts_cnt;
        end
    end

    assign line_timestamp = ts_q[rd_page];
`else
    assign line_timestamp = '0;
`endif
endmodule
